// File: rtl/axi_lite_ram_slave.sv
// Single-beat AXI4-lite RAM slave with independent read/write engines,
// programmable response latency, byte strobes and handshake counters.
module axi_lite_ram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int READ_LAT   = 2,
    parameter int WRITE_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = 16;

    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;

    logic [1:0]            r_state_reg;
    logic [CNT_W-1:0]      r_cnt_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [31:0]           rd_count_reg;

    logic [1:0]            w_state_reg;
    logic [CNT_W-1:0]      w_cnt_reg;
    logic                  aw_got_reg;
    logic                  w_got_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [NBYTES-1:0]     wstrb_reg;
    logic [31:0]           wr_count_reg;

    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_strb;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  commit;
    logic                  unused_addr_bits;

    // Upper address bits are deliberately ignored so addresses alias modulo depth.
    assign unused_addr_bits = ^{s_araddr[ADDR_WIDTH-1:IDX_W], s_awaddr[ADDR_WIDTH-1:IDX_W]};

    assign s_arready = (r_state_reg == R_IDLE);
    assign s_rvalid  = (r_state_reg == R_RESP);
    assign s_rdata   = rdata_reg;
    assign s_awready = (w_state_reg == W_IDLE) && !aw_got_reg;
    assign s_wready  = (w_state_reg == W_IDLE) && !w_got_reg;
    assign s_bvalid  = (w_state_reg == W_RESP);
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;

    assign rd_idx  = s_araddr[IDX_W-1:0];
    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    // Commit on the edge where the later of the two channels is accepted.
    assign commit  = (w_state_reg == W_IDLE) && (aw_got_reg || aw_fire) && (w_got_reg || w_fire);
    assign wr_idx  = aw_got_reg ? aw_idx_reg : s_awaddr[IDX_W-1:0];
    assign wr_data = w_got_reg ? wdata_reg : s_wdata;
    assign wr_strb = w_got_reg ? wstrb_reg : s_wstrb;

    // One byte-lane array per strobe bit; a read at the commit edge sees old data.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < MEM_WORDS; i++) begin
                        lane_mem[i] <= 8'h00;
                    end
                end else if (commit && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg  <= R_IDLE;
            r_cnt_reg    <= '0;
            rdata_reg    <= '0;
            rd_count_reg <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (s_arvalid) begin
                        rdata_reg   <= rd_word;
                        r_cnt_reg   <= CNT_W'(READ_LAT - 1);
                        r_state_reg <= (READ_LAT == 1) ? R_RESP : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_reg == '0) begin
                        r_state_reg <= R_RESP;
                    end else begin
                        r_cnt_reg <= r_cnt_reg - 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        rdata_reg    <= '0;
                        rd_count_reg <= rd_count_reg + 32'd1;
                        r_state_reg  <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg  <= W_IDLE;
            w_cnt_reg    <= '0;
            aw_got_reg   <= 1'b0;
            w_got_reg    <= 1'b0;
            aw_idx_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            wr_count_reg <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (commit) begin
                        aw_got_reg  <= 1'b0;
                        w_got_reg   <= 1'b0;
                        w_cnt_reg   <= CNT_W'(WRITE_LAT - 1);
                        w_state_reg <= (WRITE_LAT == 1) ? W_RESP : W_WAIT;
                    end else begin
                        if (aw_fire) begin
                            aw_got_reg <= 1'b1;
                            aw_idx_reg <= s_awaddr[IDX_W-1:0];
                        end
                        if (w_fire) begin
                            w_got_reg <= 1'b1;
                            wdata_reg <= s_wdata;
                            wstrb_reg <= s_wstrb;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_reg == '0) begin
                        w_state_reg <= W_RESP;
                    end else begin
                        w_cnt_reg <= w_cnt_reg - 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        wr_count_reg <= wr_count_reg + 32'd1;
                        w_state_reg  <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomized self-checking bench for axi_lite_ram_slave against a word-array
// reference model with handshake counters.
module tb_axi_lite_ram_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4096;
    localparam int RL = 2;
    localparam int WL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic          s_rvalid;
    logic          s_rready;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic          s_bvalid;
    logic          s_bready;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [MW];
    int unsigned model_rd;
    int unsigned model_wr;

    axi_lite_ram_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW),
        .READ_LAT(RL), .WRITE_LAT(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < MW; i++) model_mem[i] = 32'h0;
        model_rd = 0;
        model_wr = 0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr % MW);
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one read; lat = edges from AR capture to first rvalid, -1 on timeout.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int k;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        k = 0;
        while (!s_arready && k < 50) begin step(); k++; end
        step();
        s_arvalid = 1'b0;
        lat = 0;
        while (!s_rvalid && lat < 50) begin step(); lat++; end
        data = s_rdata;
        if (!s_rvalid) begin
            lat = -1;
        end else begin
            s_rready = 1'b1;
            step();
            s_rready = 1'b0;
            model_rd++;
        end
    endtask

    // w_lead > 0: W presented that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output int lat);
        int t;
        int aw_start;
        int w_start;
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        t = 0; aw_done = 0; w_done = 0;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        while (!(aw_done && w_done) && t < 60) begin
            s_awvalid = (t >= aw_start) && !aw_done;
            s_wvalid  = (t >= w_start) && !w_done;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            step();
            t++;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        lat = 0;
        if (!(aw_done && w_done)) begin
            lat = -1;
        end else begin
            while (!s_bvalid && lat < 50) begin step(); lat++; end
            if (!s_bvalid) begin
                lat = -1;
            end else begin
                s_bready = 1'b1;
                step();
                s_bready = 1'b0;
                model_wr++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++; if (s_arready !== 1'b1) begin n_fail++; $display("FAIL reset_arready got %b expected 1", s_arready); end
        n_tests++; if (s_awready !== 1'b1) begin n_fail++; $display("FAIL reset_awready got %b expected 1", s_awready); end
        n_tests++; if (s_wready !== 1'b1) begin n_fail++; $display("FAIL reset_wready got %b expected 1", s_wready); end
        n_tests++; if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b expected 0", s_rvalid); end
        n_tests++; if (s_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got %b expected 0", s_bvalid); end
        n_tests++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h expected 0", s_rdata); end
        n_tests++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d expected 0/0", rd_count, wr_count); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_basic_read();
        logic [31:0] d;
        int lat;
        do_read(32'h10, d, lat);
        n_tests++; if (lat != RL) begin n_fail++; $display("FAIL basic_read_lat got %0d expected %0d", lat, RL); end
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL basic_read_data got %h expected 00000000", d); end
        n_tests++; if (rd_count !== 32'(model_rd)) begin n_fail++; $display("FAIL basic_rd_count got %0d expected %0d", rd_count, model_rd); end
        n_tests++; if (s_rdata !== 32'h0) begin n_fail++; $display("FAIL rdata_cleared got %h expected 00000000", s_rdata); end
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] d;
        int lat;
        do_write(32'h5, 32'hDEADBEEF, 4'hF, 0, lat);
        model_write(32'h5, 32'hDEADBEEF, 4'hF);
        n_tests++; if (lat != WL) begin n_fail++; $display("FAIL write_same_lat got %0d expected %0d", lat, WL); end
        do_read(32'h5, d, lat);
        n_tests++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_same_data got %h expected deadbeef", d); end
        n_tests++; if (wr_count !== 32'(model_wr)) begin n_fail++; $display("FAIL wr_count got %0d expected %0d", wr_count, model_wr); end
    endtask

    task automatic test_write_w_first();
        logic [31:0] d;
        int lat;
        do_write(32'h5, 32'h11223344, 4'b0101, 3, lat);
        model_write(32'h5, 32'h11223344, 4'b0101);
        n_tests++; if (lat != WL) begin n_fail++; $display("FAIL w_first_lat got %0d expected %0d", lat, WL); end
        do_read(32'h5, d, lat);
        n_tests++; if (d !== 32'hDE22BE44 || d !== model_mem[5]) begin n_fail++; $display("FAIL w_first_data got %h expected de22be44", d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        int k;
        bit bad;
        s_araddr  = 32'h5;
        s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        k = 0;
        while (!s_rvalid && k < 50) begin step(); k++; end
        d0 = s_rdata;
        n_tests++; if (!s_rvalid || d0 !== model_mem[5]) begin n_fail++; $display("FAIL bp_first got valid=%b data=%h expected valid=1 data=%h", s_rvalid, d0, model_mem[5]); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_rvalid !== 1'b1 || s_rdata !== d0 || s_arready !== 1'b0) bad = 1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL bp_hold got valid=%b data=%h arready=%b expected 1/%h/0", s_rvalid, s_rdata, s_arready, d0); end
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        model_rd++;
        n_tests++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b arready=%b expected 0/1", s_rvalid, s_arready); end
        n_tests++; if (rd_count !== 32'(model_rd)) begin n_fail++; $display("FAIL bp_rd_count got %0d expected %0d", rd_count, model_rd); end
    endtask

    task automatic test_same_edge();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] old_val;
        int lr;
        int lw;
        old_val = $urandom;
        do_write(32'h7, old_val, 4'hF, 0, lw);
        model_write(32'h7, old_val, 4'hF);
        fork
            do_read(32'h7, d1, lr);
            do_write(32'h7, 32'hA5A5A5A5, 4'hF, 0, lw);
        join
        n_tests++; if (d1 !== old_val) begin n_fail++; $display("FAIL same_edge_old got %h expected %h", d1, old_val); end
        model_write(32'h7, 32'hA5A5A5A5, 4'hF);
        do_read(32'h7, d2, lr);
        n_tests++; if (d2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL same_edge_new got %h expected a5a5a5a5", d2); end
    endtask

    task automatic test_alias();
        logic [31:0] d;
        logic [31:0] v;
        int lat;
        v = $urandom;
        do_write(32'(MW + 3), v, 4'hF, -1, lat);
        model_write(32'(MW + 3), v, 4'hF);
        do_read(32'h3, d, lat);
        n_tests++; if (d !== v) begin n_fail++; $display("FAIL alias_low got %h expected %h", d, v); end
        do_read(32'(MW * 5 + 3), d, lat);
        n_tests++; if (d !== model_mem[3]) begin n_fail++; $display("FAIL alias_high got %h expected %h", d, model_mem[3]); end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] d;
        logic [3:0]  strb;
        int lat;
        for (int i = 0; i < 40; i++) begin
            addr = {$urandom_range(255), 24'h0} | 32'($urandom_range(15));
            if ($urandom_range(1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(15));
                do_write(addr, data, strb, int'($urandom_range(4)) - 2, lat);
                model_write(addr, data, strb);
                n_tests++; if (lat != WL) begin n_fail++; $display("FAIL rand_write_lat addr=%h got %0d expected %0d", addr, lat, WL); end
            end else begin
                do_read(addr, d, lat);
                n_tests++; if (lat != RL || d !== model_mem[addr % MW]) begin n_fail++; $display("FAIL rand_read addr=%h got %h lat %0d expected %h lat %0d", addr, d, lat, model_mem[addr % MW], RL); end
            end
        end
        n_tests++; if (rd_count !== 32'(model_rd) || wr_count !== 32'(model_wr)) begin n_fail++; $display("FAIL rand_counts got %0d/%0d expected %0d/%0d", rd_count, wr_count, model_rd, model_wr); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        int lat;
        bit bad;
        s_araddr  = 32'h3;
        s_arvalid = 1'b1;
        s_awaddr  = 32'h3;
        s_wdata   = 32'hCAFEF00D;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        step();
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        rst_n = 1'b0;
        #2;
        n_tests++; if (s_arready !== 1'b1 || s_awready !== 1'b1 || s_rvalid !== 1'b0 || s_bvalid !== 1'b0) begin n_fail++; $display("FAIL midflight_reset got ar=%b aw=%b rv=%b bv=%b expected 1/1/0/0", s_arready, s_awready, s_rvalid, s_bvalid); end
        #2;
        rst_n = 1'b1;
        model_reset();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_rvalid !== 1'b0 || s_bvalid !== 1'b0) bad = 1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL midflight_no_resp got rvalid/bvalid asserted expected none"); end
        n_tests++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin n_fail++; $display("FAIL midflight_counts got %0d/%0d expected 0/0", rd_count, wr_count); end
        do_read(32'h3, d, lat);
        n_tests++; if (d !== model_mem[3]) begin n_fail++; $display("FAIL midflight_mem got %h expected %h", d, model_mem[3]); end
    endtask

    initial begin
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_wvalid = 1'b0; s_bready = 1'b0;
        test_reset();
        test_basic_read();
        test_write_same_cycle();
        test_write_w_first();
        test_backpressure();
        test_same_edge();
        test_alias();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
